// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle between the pipeline stages and the stall/flush sequencer.
//   Handshake: request inputs are sampled by the controller on every rising
//   clock edge. stall, busy_div, div_done and bus_timeout are valid in the
//   same cycle as the requests. flush and new_pc are registered and valid
//   for exactly the one cycle after a redirect trigger. There is no
//   ready/back-pressure path; the stages obey stall and flush as given.
//
//   master : pipeline side (drives requests, receives control)
//   slave  : pipeline_ctrl side
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              stallreq_id;
  logic              div_start;
  logic              stallreq_mem;
  logic              excp_req;
  logic              eret_req;
  logic [ADDR_W-1:0] cp0_epc;
  logic [5:0]        stall;
  logic              flush;
  logic [ADDR_W-1:0] new_pc;
  logic              busy_div;
  logic              div_done;
  logic              bus_timeout;

  modport master (
    output stallreq_id, div_start, stallreq_mem, excp_req, eret_req, cp0_epc,
    input  stall, flush, new_pc, busy_div, div_done, bus_timeout
  );

  modport slave (
    input  stallreq_id, div_start, stallreq_mem, excp_req, eret_req, cp0_epc,
    output stall, flush, new_pc, busy_div, div_done, bus_timeout
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline.
//   Merges ID/EX/MEM stall requests into one freeze mask, owns the divide
//   busy counter and the bus-wait timeout counter, and sequences the one
//   cycle flush with redirect PC on exception / ERET / bus timeout.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active high
//   bus          slave side of pipeline_ctrl_if (requests in, control out)
//   o_dbg_state  out  current FSM state (RUN=0, DIV=1, FLUSH=2)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] EXC_VEC     = 32'h00000020,
  parameter int                DIV_CYCLES  = 32,
  parameter int                MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_ctrl_if.slave       bus,
  output logic [1:0]           o_dbg_state
);

  localparam int DIV_W = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DIV   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [7:0]        r_mem_cnt;
  logic              r_flush;
  logic [ADDR_W-1:0] r_new_pc;

  logic       w_active;
  logic       w_bus_timeout;
  logic       w_trig;
  logic       w_div_busy;
  logic       w_div_start;
  logic       w_ex_stall;
  logic [5:0] w_stall;

  // Requests are only honoured in RUN/DIV; FLUSH ignores everything.
  assign w_active      = ~rst & (r_state != FLUSH);
  assign w_bus_timeout = w_active & bus.stallreq_mem &
                         (r_mem_cnt == 8'(MEM_TIMEOUT - 1));
  assign w_trig        = w_active &
                         (bus.excp_req | bus.eret_req | w_bus_timeout);
  assign w_div_busy    = (r_state == DIV) & (r_div_cnt != '0);
  // A redirect in the same cycle suppresses the divide start.
  assign w_div_start   = w_active & (r_state == RUN) & bus.div_start & ~w_trig;
  assign w_ex_stall    = w_div_start | w_div_busy;

  always_comb begin
    w_stall = 6'b000000;
    if (w_active) begin
      if (w_trig)                w_stall = 6'b111111;
      else if (bus.stallreq_mem) w_stall = 6'b011111;
      else if (w_ex_stall)       w_stall = 6'b001111;
      else if (bus.stallreq_id)  w_stall = 6'b000111;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RUN;
      r_div_cnt <= '0;
      r_mem_cnt <= 8'd0;
      r_flush   <= 1'b0;
      r_new_pc  <= '0;
    end else begin
      case (r_state)
        FLUSH: begin
          r_state   <= RUN;
          r_flush   <= 1'b0;
          r_div_cnt <= '0;
          r_mem_cnt <= 8'd0;
        end
        default: begin
          // Consecutive MEM wait cycles; saturates rather than wrapping.
          if (!bus.stallreq_mem || w_bus_timeout) r_mem_cnt <= 8'd0;
          else if (r_mem_cnt != 8'hFF)            r_mem_cnt <= r_mem_cnt + 8'd1;

          if (w_trig) begin
            r_state   <= FLUSH;
            r_flush   <= 1'b1;
            r_div_cnt <= '0;
            r_new_pc  <= (bus.excp_req | w_bus_timeout) ? EXC_VEC : bus.cp0_epc;
          end else if (r_state == RUN) begin
            if (bus.div_start) begin
              r_state   <= DIV;
              r_div_cnt <= DIV_W'(DIV_CYCLES);
            end
          end else begin
            // DIV: count down, the zero cycle is the div_done cycle.
            if (r_div_cnt != '0) r_div_cnt <= r_div_cnt - DIV_W'(1);
            else                 r_state   <= RUN;
          end
        end
      endcase
    end
  end

  assign bus.stall       = w_stall;
  assign bus.flush       = r_flush;
  assign bus.new_pc      = r_new_pc;
  assign bus.busy_div    = ~rst & w_div_busy;
  assign bus.div_done    = ~rst & (r_state == DIV) & (r_div_cnt == '0) & ~w_trig;
  assign bus.bus_timeout = w_bus_timeout;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed sequences followed by random traffic. Every cycle the driver
//   computes the expected outputs from a cycle-count reference model and
//   pushes them; a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int          ADDR_W  = 32;
  localparam logic [31:0] EXC     = 32'h00000020;
  localparam int          DIV_C   = 4;
  localparam int          MEM_TO  = 8;
  localparam int          W       = 6 + 1 + 32 + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] dbg_state;

  pipeline_ctrl_if #(.ADDR_W(ADDR_W)) pc_if ();

  pipeline_ctrl #(
    .ADDR_W(ADDR_W), .EXC_VEC(EXC), .DIV_CYCLES(DIV_C), .MEM_TIMEOUT(MEM_TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(pc_if.slave), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since divide start (0 = none),
  // length of the current MEM wait streak, pending flush.
  int          div_age    = 0;
  int          mem_streak = 0;
  bit          m_flush    = 0;
  logic [31:0] m_pc       = '0;

  task automatic model_step(input bit id, input bit ds, input bit mem,
                            input bit ex, input bit er, input logic [31:0] epc,
                            output logic [W-1:0] e);
    logic [5:0] st;
    bit busy, done, bto, trig, starting;
    int streak;
    st = 6'd0; busy = 0; done = 0; bto = 0;
    if (rst) begin
      div_age = 0; mem_streak = 0; m_flush = 0;
      e = '0;
    end else if (m_flush) begin
      e = {6'd0, 1'b1, m_pc, 3'b000};
      m_flush = 0; div_age = 0; mem_streak = 0;
    end else begin
      busy   = (div_age >= 1) && (div_age <= DIV_C);
      streak = mem ? mem_streak + 1 : 0;
      bto    = mem && (streak == MEM_TO);
      trig   = ex || er || bto;
      if (trig) begin
        st = 6'h3F;
        m_pc = (ex || bto) ? EXC : epc;
        m_flush = 1; div_age = 0; mem_streak = 0;
      end else begin
        starting = (div_age == 0) && ds;
        done     = (div_age == DIV_C + 1);
        if (mem)                   st = 6'h1F;
        else if (starting || busy) st = 6'h0F;
        else if (id)               st = 6'h07;
        if (starting)                           div_age = 1;
        else if (div_age > 0 && div_age <= DIV_C) div_age = div_age + 1;
        else                                    div_age = 0;
        mem_streak = streak;
      end
      e = {st, 1'b0, 32'd0, busy, done, bto};
    end
  endtask

  task automatic drive_cycle(input bit id, input bit ds, input bit mem,
                             input bit ex, input bit er, input logic [31:0] epc);
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    pc_if.stallreq_id  = id;
    pc_if.div_start    = ds;
    pc_if.stallreq_mem = mem;
    pc_if.excp_req     = ex;
    pc_if.eret_req     = er;
    pc_if.cp0_epc      = epc;
    model_step(id, ds, mem, ex, er, epc, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0, 0, 32'h0);
  endtask

  // Monitor: outputs are stable by the falling edge.
  initial begin
    logic [W-1:0] e, g;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {pc_if.stall, pc_if.flush, pc_if.new_pc,
             pc_if.busy_div, pc_if.div_done, pc_if.bus_timeout};
        if (!e[35]) g[34:3] = 32'd0;  // new_pc only meaningful with flush
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got stall=%b flush=%b pc=%h busy=%b done=%b bto=%b exp stall=%b flush=%b pc=%h busy=%b done=%b bto=%b",
                   $time, g[41:36], g[35], g[34:3], g[2], g[1], g[0],
                   e[41:36], e[35], e[34:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  task automatic check_direct(input string name, input logic [63:0] got,
                              input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask

  initial begin
    logic [W-1:0] e;
    int mem_left;
    bit id, ds, mem, ex, er;
    pc_if.stallreq_id = 0; pc_if.div_start = 0; pc_if.stallreq_mem = 0;
    pc_if.excp_req = 0; pc_if.eret_req = 0; pc_if.cp0_epc = '0;

    // Reset: outputs 0 while held.
    idle(3);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Load-use stall for one cycle.
    drive_cycle(1, 0, 0, 0, 0, 32'h0);
    idle(2);
    // Divide: 5 stalled cycles then div_done.
    drive_cycle(0, 1, 0, 0, 0, 32'h0);
    idle(7);
    // Exception pulse.
    drive_cycle(0, 0, 0, 1, 0, 32'h0);
    idle(3);
    // ERET, then ERET with concurrent exception.
    drive_cycle(0, 0, 0, 0, 1, 32'h00001040);
    idle(3);
    drive_cycle(0, 0, 0, 1, 1, 32'h00001040);
    idle(3);
    // MEM wait held to timeout and beyond into the flush.
    for (int i = 0; i < 10; i++) drive_cycle(0, 0, 1, 0, 0, 32'h0);
    idle(2);
    // Exception on the 2nd DIV cycle aborts the divide.
    drive_cycle(0, 1, 0, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 0, 0, 32'h0);
    drive_cycle(0, 0, 0, 1, 0, 32'h0);
    idle(4);
    // div_start together with excp_req: no divide.
    drive_cycle(0, 1, 0, 1, 0, 32'h0);
    idle(4);
    // Divide with MEM wait overlapping and an id request.
    drive_cycle(1, 1, 1, 0, 0, 32'h0);
    drive_cycle(1, 0, 1, 0, 0, 32'h0);
    idle(6);

    // Asynchronous reset between edges in the middle of a divide.
    drive_cycle(0, 1, 0, 0, 0, 32'h0);
    idle(2);
    @(posedge clk); #1;
    rst = 1'b1;  // model state cleared; expect zeros this cycle
    model_step(0, 0, 0, 0, 0, 32'h0, e);
    exp_q.push_back(e);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_direct("async_rst_outputs",
                 {pc_if.stall, pc_if.flush, pc_if.busy_div, pc_if.div_done,
                  pc_if.bus_timeout}, 64'd0);
    @(posedge clk); #1;
    model_step(0, 0, 0, 0, 0, 32'h0, e);
    exp_q.push_back(e);
    #1 rst = 1'b0;
    #1 check_direct("state_after_rst", {62'd0, dbg_state}, 64'd0);
    idle(3);

    // Random traffic with bursty MEM waits.
    mem_left = 0;
    for (int c = 0; c < 1500; c++) begin
      if (mem_left == 0 && $urandom_range(0, 9) == 0) mem_left = $urandom_range(1, 12);
      mem = (mem_left > 0);
      if (mem_left > 0) mem_left--;
      id = ($urandom_range(0, 9) < 3);
      ds = ($urandom_range(0, 9) == 0);
      ex = ($urandom_range(0, 49) == 0);
      er = ($urandom_range(0, 49) == 0);
      drive_cycle(id, ds, mem, ex, er, $urandom());
    end
    idle(2);

    @(negedge clk); #1;
    check_direct("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
